exe_sched: RTL and testbench

EXE_SCHED -- requirements
Module: exe_sched

---
 rtl/exe_pkg.sv | 17 +
 rtl/rr_arb2.sv | 39 +++
 rtl/exe_sched.sv | 130 +++++++++++++
 tb/tb_exe_sched.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// Shared opcode and FSM state types for the execution scheduler.
package exe_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_CMP  = 2'd1,
    OP_SET  = 2'd2,
    OP_CONV = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; pointer moves to the non-served requester on update.
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_upd,
  input  logic       i_served,
  output logic [1:0] o_gnt
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (i_upd) begin
      ptr_d = ~i_served;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_comb begin
    o_gnt = '0;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = ptr_q ? 2'b10 : 2'b01;
      default: o_gnt = '0;
    endcase
  end

endmodule

// File: rtl/exe_sched.sv
// Two-requester scheduler feeding a combinational execution unit; one op in flight.
module exe_sched
  import exe_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNTW  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [1:0]            i_req_valid,
  input  logic [1:0][1:0]       i_req_oper,
  input  logic [1:0][WIDTH-1:0] i_req_argA,
  input  logic [1:0][WIDTH-1:0] i_req_argB,
  output logic [1:0]            o_req_ready,
  output logic [WIDTH-1:0]      o_argA,
  output logic [WIDTH-1:0]      o_argB,
  output logic [1:0]            o_oper,
  input  logic [WIDTH-1:0]      i_result,
  input  logic                  i_error,
  input  logic                  i_carry,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic                  o_rsp_id,
  output logic [WIDTH-1:0]      o_rsp_result,
  output logic                  o_rsp_error,
  output logic                  o_rsp_carry,
  output logic                  o_busy,
  output logic [CNTW-1:0]       o_op_cnt
);

  state_e           state_q, state_d;
  op_e              oper_q, oper_d;
  logic [WIDTH-1:0] arga_q, arga_d;
  logic [WIDTH-1:0] argb_q, argb_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_error_q, rsp_error_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  logic [1:0] gnt;
  logic       win;
  logic       rsp_hs;

  assign rsp_hs = (state_q == ST_RESP) && i_rsp_ready;
  assign win    = gnt[1];

  rr_arb2 u_arb (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_req    (i_req_valid),
    .i_upd    (rsp_hs),
    .i_served (id_q),
    .o_gnt    (gnt)
  );

  always_comb begin
    state_d      = state_q;
    oper_d       = oper_q;
    arga_d       = arga_q;
    argb_d       = argb_q;
    id_d         = id_q;
    rsp_result_d = rsp_result_q;
    rsp_error_d  = rsp_error_q;
    rsp_carry_d  = rsp_carry_q;
    cnt_d        = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|i_req_valid) begin
          oper_d  = op_e'(i_req_oper[win]);
          arga_d  = i_req_argA[win];
          argb_d  = i_req_argB[win];
          id_d    = win;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Error is only meaningful for set/convert, carry only for add.
        rsp_result_d = i_result;
        rsp_error_d  = ((oper_q == OP_SET) || (oper_q == OP_CONV)) ? i_error : 1'b0;
        rsp_carry_d  = (oper_q == OP_ADD) ? i_carry : 1'b0;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          cnt_d   = cnt_q + CNTW'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      oper_q       <= OP_ADD;
      arga_q       <= '0;
      argb_q       <= '0;
      id_q         <= 1'b0;
      rsp_result_q <= '0;
      rsp_error_q  <= 1'b0;
      rsp_carry_q  <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      oper_q       <= oper_d;
      arga_q       <= arga_d;
      argb_q       <= argb_d;
      id_q         <= id_d;
      rsp_result_q <= rsp_result_d;
      rsp_error_q  <= rsp_error_d;
      rsp_carry_q  <= rsp_carry_d;
      cnt_q        <= cnt_d;
    end
  end

  assign o_req_ready  = (i_rst_n && (state_q == ST_IDLE)) ? gnt : '0;
  assign o_busy       = i_rst_n && (state_q != ST_IDLE);
  assign o_rsp_valid  = (state_q == ST_RESP);
  assign o_argA       = arga_q;
  assign o_argB       = argb_q;
  assign o_oper       = oper_q;
  assign o_rsp_id     = id_q;
  assign o_rsp_result = rsp_result_q;
  assign o_rsp_error  = rsp_error_q;
  assign o_rsp_carry  = rsp_carry_q;
  assign o_op_cnt     = cnt_q;

endmodule

// File: tb/tb_exe_sched.sv
// Directed self-checking bench for exe_sched with a behavioural execution unit.
module tb_exe_sched;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNTW  = 4;

  logic                  i_clk = 1'b0;
  logic                  i_rst_n;
  logic [1:0]            i_req_valid;
  logic [1:0][1:0]       i_req_oper;
  logic [1:0][WIDTH-1:0] i_req_argA;
  logic [1:0][WIDTH-1:0] i_req_argB;
  logic [1:0]            o_req_ready;
  logic [WIDTH-1:0]      o_argA, o_argB;
  logic [1:0]            o_oper;
  logic [WIDTH-1:0]      i_result;
  logic                  i_error, i_carry;
  logic                  o_rsp_valid;
  logic                  i_rsp_ready;
  logic                  o_rsp_id;
  logic [WIDTH-1:0]      o_rsp_result;
  logic                  o_rsp_error, o_rsp_carry;
  logic                  o_busy;
  logic [CNTW-1:0]       o_op_cnt;

  logic cfg_error, cfg_carry;
  int   checks = 0;
  int   errors = 0;

  exe_sched #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .i_req_oper(i_req_oper),
    .i_req_argA(i_req_argA), .i_req_argB(i_req_argB),
    .o_req_ready(o_req_ready), .o_argA(o_argA), .o_argB(o_argB), .o_oper(o_oper),
    .i_result(i_result), .i_error(i_error), .i_carry(i_carry),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_id(o_rsp_id),
    .o_rsp_result(o_rsp_result), .o_rsp_error(o_rsp_error), .o_rsp_carry(o_rsp_carry),
    .o_busy(o_busy), .o_op_cnt(o_op_cnt)
  );

  always #5 i_clk = ~i_clk;

  // Execution unit: add, subtract, pass B, invert A.
  always_comb begin
    case (o_oper)
      2'd0:    i_result = o_argA + o_argB;
      2'd1:    i_result = o_argA - o_argB;
      2'd2:    i_result = o_argB;
      default: i_result = ~o_argA;
    endcase
    i_error = cfg_error;
    i_carry = cfg_carry;
  end

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_req_valid = '0;
    i_req_oper = '0;
    i_req_argA = '0;
    i_req_argB = '0;
    i_rsp_ready = 1'b1;
    cfg_error = 1'b0;
    cfg_carry = 1'b0;
    next_cycle();
    next_cycle();
    i_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    i_rst_n = 1'b0;
    i_req_valid = 2'b11;
    @(negedge i_clk);
    checks++; if (o_req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready got %b exp 00", o_req_ready); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", o_busy); end
    next_cycle();
    i_rst_n = 1'b1;
    i_req_valid = '0;
    @(negedge i_clk);
    checks++; if (o_rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b exp 0", o_rsp_valid); end
    checks++; if (o_argA !== '0 || o_argB !== '0 || o_oper !== 2'd0) begin errors++; $display("FAIL rst_args got %h %h %0d exp 0 0 0", o_argA, o_argB, o_oper); end
    checks++; if (o_op_cnt !== '0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", o_op_cnt); end
    checks++; if (o_rsp_result !== '0 || o_rsp_id !== 1'b0 || o_rsp_error !== 1'b0 || o_rsp_carry !== 1'b0) begin errors++; $display("FAIL rst_rsp got %h id %b err %b car %b exp zeros", o_rsp_result, o_rsp_id, o_rsp_error, o_rsp_carry); end
    next_cycle();
  endtask

  task automatic test_single_add();
    do_reset();
    i_req_valid = 2'b01;
    i_req_oper[0] = 2'd0;
    i_req_argA[0] = 32'd5;
    i_req_argB[0] = 32'd7;
    cfg_carry = 1'b1;
    @(negedge i_clk);
    checks++; if (o_req_ready !== 2'b01) begin errors++; $display("FAIL add_ready_c1 got %b exp 01", o_req_ready); end
    next_cycle();
    i_req_valid = '0;
    @(negedge i_clk);
    checks++; if (o_busy !== 1'b1 || o_rsp_valid !== 1'b0) begin errors++; $display("FAIL add_exec_c2 got busy %b valid %b exp 1 0", o_busy, o_rsp_valid); end
    checks++; if (o_argA !== 32'd5 || o_argB !== 32'd7) begin errors++; $display("FAIL add_args got %0d %0d exp 5 7", o_argA, o_argB); end
    next_cycle();
    @(negedge i_clk);
    checks++; if (o_rsp_valid !== 1'b1) begin errors++; $display("FAIL add_valid_c3 got %b exp 1", o_rsp_valid); end
    checks++; if (o_rsp_result !== 32'd12 || o_rsp_carry !== 1'b1 || o_rsp_id !== 1'b0) begin errors++; $display("FAIL add_payload got %0d car %b id %b exp 12 1 0", o_rsp_result, o_rsp_carry, o_rsp_id); end
    next_cycle();
    @(negedge i_clk);
    checks++; if (o_op_cnt !== 4'd1 || o_busy !== 1'b0) begin errors++; $display("FAIL add_cnt got %0d busy %b exp 1 0", o_op_cnt, o_busy); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    int gseq[$];
    int rseq[$];
    logic [WIDTH-1:0] exp_res [2];
    int exp_g [4] = '{0, 1, 0, 1};
    do_reset();
    exp_res[0] = 32'd13;
    exp_res[1] = 32'd101;
    i_req_valid = 2'b11;
    i_req_oper = '0;
    i_req_argA[0] = 32'd10;
    i_req_argB[0] = 32'd3;
    i_req_argA[1] = 32'd100;
    i_req_argB[1] = 32'd1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge i_clk);
      if (o_req_ready !== 2'b00) gseq.push_back(o_req_ready[1] ? 1 : 0);
      if (o_rsp_valid === 1'b1) begin
        rseq.push_back(int'(o_rsp_id));
        checks++; if (o_rsp_result !== exp_res[o_rsp_id]) begin errors++; $display("FAIL b2b_result c%0d got %0d exp %0d", c, o_rsp_result, exp_res[o_rsp_id]); end
      end
      next_cycle();
    end
    i_req_valid = '0;
    checks++; if (gseq.size() != 4) begin errors++; $display("FAIL b2b_grants got %0d exp 4", gseq.size()); end
    checks++; if (rseq.size() != 4) begin errors++; $display("FAIL b2b_rsps got %0d exp 4", rseq.size()); end
    for (int k = 0; k < 4; k++) begin
      if (k < gseq.size()) begin
        checks++; if (gseq[k] != exp_g[k]) begin errors++; $display("FAIL b2b_grant%0d got %0d exp %0d", k, gseq[k], exp_g[k]); end
      end
      if (k < rseq.size()) begin
        checks++; if (rseq[k] != exp_g[k]) begin errors++; $display("FAIL b2b_id%0d got %0d exp %0d", k, rseq[k], exp_g[k]); end
      end
    end
    @(negedge i_clk);
    checks++; if (o_op_cnt !== 4'd4) begin errors++; $display("FAIL b2b_cnt got %0d exp 4", o_op_cnt); end
  endtask

  task automatic test_flags();
    do_reset();
    i_req_valid = 2'b01;
    i_req_oper[0] = 2'd1;
    i_req_argA[0] = 32'd9;
    i_req_argB[0] = 32'd4;
    cfg_error = 1'b1;
    cfg_carry = 1'b1;
    next_cycle();
    i_req_valid = '0;
    next_cycle();
    @(negedge i_clk);
    checks++; if (o_rsp_valid !== 1'b1 || o_rsp_result !== 32'd5) begin errors++; $display("FAIL cmp_result got v%b %0d exp v1 5", o_rsp_valid, o_rsp_result); end
    checks++; if (o_rsp_error !== 1'b0 || o_rsp_carry !== 1'b0) begin errors++; $display("FAIL cmp_flags got err %b car %b exp 0 0", o_rsp_error, o_rsp_carry); end
    next_cycle();
    i_req_valid = 2'b01;
    i_req_oper[0] = 2'd3;
    i_req_argA[0] = 32'h0000_00F0;
    next_cycle();
    i_req_valid = '0;
    next_cycle();
    @(negedge i_clk);
    checks++; if (o_rsp_valid !== 1'b1 || o_rsp_result !== 32'hFFFF_FF0F) begin errors++; $display("FAIL conv_result got v%b %h exp v1 ffffff0f", o_rsp_valid, o_rsp_result); end
    checks++; if (o_rsp_error !== 1'b1 || o_rsp_carry !== 1'b0) begin errors++; $display("FAIL conv_flags got err %b car %b exp 1 0", o_rsp_error, o_rsp_carry); end
    next_cycle();
  endtask

  task automatic test_stall();
    do_reset();
    i_rsp_ready = 1'b0;
    i_req_valid = 2'b01;
    i_req_oper[0] = 2'd2;
    i_req_argA[0] = 32'd1;
    i_req_argB[0] = 32'h55;
    i_req_oper[1] = 2'd0;
    @(negedge i_clk);
    checks++; if (o_req_ready !== 2'b01) begin errors++; $display("FAIL stall_grant0 got %b exp 01", o_req_ready); end
    next_cycle();
    i_req_valid = 2'b10;
    @(negedge i_clk);
    checks++; if (o_req_ready !== 2'b00) begin errors++; $display("FAIL stall_exec_ready got %b exp 00", o_req_ready); end
    next_cycle();
    for (int c = 3; c <= 7; c++) begin
      @(negedge i_clk);
      checks++; if (o_rsp_valid !== 1'b1 || o_rsp_result !== 32'h55 || o_rsp_id !== 1'b0) begin errors++; $display("FAIL stall_hold c%0d got v%b %h id %b exp v1 55 0", c, o_rsp_valid, o_rsp_result, o_rsp_id); end
      checks++; if (o_req_ready !== 2'b00) begin errors++; $display("FAIL stall_ready c%0d got %b exp 00", c, o_req_ready); end
      next_cycle();
    end
    i_rsp_ready = 1'b1;
    @(negedge i_clk);
    checks++; if (o_rsp_valid !== 1'b1 || o_req_ready !== 2'b00) begin errors++; $display("FAIL stall_hs got v%b r%b exp v1 r00", o_rsp_valid, o_req_ready); end
    next_cycle();
    @(negedge i_clk);
    checks++; if (o_req_ready !== 2'b10 || o_rsp_valid !== 1'b0) begin errors++; $display("FAIL stall_grant1 got r%b v%b exp r10 v0", o_req_ready, o_rsp_valid); end
    next_cycle();
    i_req_valid = '0;
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    i_req_valid = 2'b01;
    i_req_argA[0] = 32'd3;
    i_req_argB[0] = 32'd4;
    next_cycle();
    i_req_valid = '0;
    @(negedge i_clk);
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL mid_exec_busy got %b exp 1", o_busy); end
    i_rst_n = 1'b0;
    #1;
    checks++; if (o_busy !== 1'b0 || o_req_ready !== 2'b00) begin errors++; $display("FAIL mid_rst_low got busy %b r%b exp 0 00", o_busy, o_req_ready); end
    next_cycle();
    i_rst_n = 1'b1;
    @(negedge i_clk);
    checks++; if (o_busy !== 1'b0 || o_rsp_valid !== 1'b0 || o_argA !== '0) begin errors++; $display("FAIL mid_after got busy %b v%b a%0d exp 0 0 0", o_busy, o_rsp_valid, o_argA); end
    next_cycle();
    @(negedge i_clk);
    checks++; if (o_rsp_valid !== 1'b0 || o_op_cnt !== 4'd0) begin errors++; $display("FAIL mid_cnt got v%b cnt %0d exp 0 0", o_rsp_valid, o_op_cnt); end
    next_cycle();
  endtask

  task automatic test_cnt_wrap();
    do_reset();
    i_req_valid = 2'b01;
    i_req_oper[0] = 2'd0;
    i_req_argA[0] = 32'd1;
    i_req_argB[0] = 32'd1;
    repeat (45) next_cycle();
    @(negedge i_clk);
    checks++; if (o_op_cnt !== 4'd15) begin errors++; $display("FAIL wrap_pre got %0d exp 15", o_op_cnt); end
    checks++; if (o_req_ready !== 2'b01) begin errors++; $display("FAIL wrap_grant16 got %b exp 01", o_req_ready); end
    next_cycle();
    i_req_valid = '0;
    next_cycle();
    next_cycle();
    @(negedge i_clk);
    checks++; if (o_op_cnt !== 4'd0 || o_busy !== 1'b0) begin errors++; $display("FAIL wrap_post got %0d busy %b exp 0 0", o_op_cnt, o_busy); end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_back_to_back();
    test_flags();
    test_stall();
    test_reset_mid_op();
    test_cnt_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
